// File: rtl/grid_scanner.sv
// Row-multiplexed 8x8 LED matrix scanner: latches one 64-bit generation snapshot,
// scans it FRAMES times with optional blanking between rows, then requests the next generation.
module grid_scanner #(
  parameter int DWELL  = 4,
  parameter int BLANK  = 1,
  parameter int FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] grid,
  input  logic        load_valid,
  output logic        load_ready,
  output logic [7:0]  row_sel,
  output logic [7:0]  col_data,
  output logic        frame_done,
  output logic        gen_req,
  output logic        busy
);

  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam int FW      = $clog2(FRAMES) + 1;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_BLANK} state_t;

  state_t        state;
  logic [63:0]   buffer;
  logic [2:0]    row;
  logic [CW-1:0] cnt;
  logic [FW-1:0] frame;

  logic       dwell_end;
  logic       blank_end;
  logic       row_adv;
  logic       last_row;
  logic       last_frame;
  logic [2:0] row_nxt;

  always_comb begin
    dwell_end  = (state == S_SCAN)  && (cnt == DWELL_LAST);
    blank_end  = (state == S_BLANK) && (cnt == BLANK_LAST);
    // Without blanking the end of the dwell moves straight on to the next row.
    row_adv    = blank_end || (dwell_end && (BLANK == 0));
    last_row   = (row == 3'd7);
    last_frame = (frame == FRAME_LAST);
    row_nxt    = row + 3'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      buffer     <= '0;
      row        <= '0;
      cnt        <= '0;
      frame      <= '0;
      load_ready <= 1'b1;
      row_sel    <= '0;
      col_data   <= '0;
      frame_done <= 1'b0;
      gen_req    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      gen_req    <= 1'b0;
      if (state == S_IDLE) begin
        if (load_valid) begin
          // Row 0 is driven straight from grid so it shows in the very next cycle.
          state      <= S_SCAN;
          buffer     <= grid;
          row        <= '0;
          cnt        <= '0;
          frame      <= '0;
          load_ready <= 1'b0;
          busy       <= 1'b1;
          row_sel    <= 8'h01;
          col_data   <= grid[7:0];
        end
      end else if (row_adv) begin
        cnt <= '0;
        if (last_row && last_frame) begin
          state      <= S_IDLE;
          frame_done <= 1'b1;
          gen_req    <= 1'b1;
          load_ready <= 1'b1;
          busy       <= 1'b0;
          row_sel    <= '0;
          col_data   <= '0;
        end else begin
          if (last_row) begin
            frame_done <= 1'b1;
            frame      <= frame + 1'b1;
          end
          state    <= S_SCAN;
          row      <= row_nxt;
          row_sel  <= 8'd1 << row_nxt;
          col_data <= buffer[{row_nxt, 3'b000} +: 8];
        end
      end else if (dwell_end) begin
        cnt      <= '0;
        state    <= S_BLANK;
        row_sel  <= '0;
        col_data <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_grid_scanner.sv
// Directed bench for grid_scanner: one instance with blanking and two frames,
// one with no blanking and a single frame.
module tb_grid_scanner;

  logic        clk;
  logic        reset_n;

  logic [63:0] grid_a;
  logic        lv_a;
  logic        lr_a;
  logic [7:0]  rs_a;
  logic [7:0]  cd_a;
  logic        fd_a;
  logic        gr_a;
  logic        busy_a;

  logic [63:0] grid_b;
  logic        lv_b;
  logic        lr_b;
  logic [7:0]  rs_b;
  logic [7:0]  cd_b;
  logic        fd_b;
  logic        gr_b;
  logic        busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  grid_scanner #(.DWELL(2), .BLANK(1), .FRAMES(2)) u_dut_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .grid      (grid_a),
    .load_valid(lv_a),
    .load_ready(lr_a),
    .row_sel   (rs_a),
    .col_data  (cd_a),
    .frame_done(fd_a),
    .gen_req   (gr_a),
    .busy      (busy_a)
  );

  grid_scanner #(.DWELL(1), .BLANK(0), .FRAMES(1)) u_dut_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .grid      (grid_b),
    .load_valid(lv_b),
    .load_ready(lr_b),
    .row_sel   (rs_b),
    .col_data  (cd_b),
    .frame_done(fd_b),
    .gen_req   (gr_b),
    .busy      (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_a_rs"},   64'(rs_a),   64'h0);
    check({tag, "_a_cd"},   64'(cd_a),   64'h0);
    check({tag, "_a_busy"}, 64'(busy_a), 64'h0);
    check({tag, "_a_lr"},   64'(lr_a),   64'h1);
    check({tag, "_a_fd"},   64'(fd_a),   64'h0);
    check({tag, "_a_gr"},   64'(gr_a),   64'h0);
  endtask

  task automatic check_idle_b(input string tag);
    check({tag, "_b_rs"},   64'(rs_b),   64'h0);
    check({tag, "_b_cd"},   64'(cd_b),   64'h0);
    check({tag, "_b_busy"}, 64'(busy_b), 64'h0);
    check({tag, "_b_lr"},   64'(lr_b),   64'h1);
    check({tag, "_b_fd"},   64'(fd_b),   64'h0);
    check({tag, "_b_gr"},   64'(gr_b),   64'h0);
  endtask

  // DUT A, cycle n after the handshake: each row is 2 lit cycles then 1 blank,
  // 24 cycles per frame, gen_req in cycle 48.
  task automatic step_a(input logic [63:0] img, input int n);
    logic [7:0] e_rs;
    logic [7:0] e_cd;
    logic       e_fd;
    logic       e_gr;
    logic       e_busy;
    logic       e_lr;
    int         pos;
    int         r;
    tick();
    if (n >= 48) begin
      e_rs = 8'h00; e_cd = 8'h00; e_fd = 1'b1; e_gr = 1'b1; e_busy = 1'b0; e_lr = 1'b1;
    end else begin
      pos = n % 24;
      r   = pos / 3;
      if ((pos % 3) != 2) begin
        e_rs = 8'(1 << r);
        e_cd = img[8*r +: 8];
      end else begin
        e_rs = 8'h00;
        e_cd = 8'h00;
      end
      e_fd = (n == 24); e_gr = 1'b0; e_busy = 1'b1; e_lr = 1'b0;
    end
    check($sformatf("a_rs_n%0d", n),   64'(rs_a),   64'(e_rs));
    check($sformatf("a_cd_n%0d", n),   64'(cd_a),   64'(e_cd));
    check($sformatf("a_fd_n%0d", n),   64'(fd_a),   64'(e_fd));
    check($sformatf("a_gr_n%0d", n),   64'(gr_a),   64'(e_gr));
    check($sformatf("a_busy_n%0d", n), 64'(busy_a), 64'(e_busy));
    check($sformatf("a_lr_n%0d", n),   64'(lr_a),   64'(e_lr));
  endtask

  localparam logic [63:0] DIAG  = 64'h8040201008040201;
  localparam logic [63:0] STRIP = 64'hFFFF_0000_FFFF_0000;
  localparam logic [63:0] ANTI  = 64'h0102040810204080;
  localparam logic [63:0] SEQ   = 64'h0123456789ABCDEF;

  initial begin
    logic [7:0] seq_bytes [0:7];
    logic [7:0] e_rs;
    logic [7:0] e_cd;

    seq_bytes[0] = 8'hEF; seq_bytes[1] = 8'hCD; seq_bytes[2] = 8'hAB; seq_bytes[3] = 8'h89;
    seq_bytes[4] = 8'h67; seq_bytes[5] = 8'h45; seq_bytes[6] = 8'h23; seq_bytes[7] = 8'h01;

    reset_n = 1'b0;
    grid_a  = '0;
    lv_a    = 1'b0;
    grid_b  = '0;
    lv_b    = 1'b0;

    #12;
    check_idle_a("rst");
    check_idle_b("rst");
    tick();
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tick();
      check_idle_a($sformatf("idle%0d", i));
      check_idle_b($sformatf("idle%0d", i));
    end

    // No blanking, one frame: rows walk on consecutive cycles.
    grid_b = SEQ;
    lv_b   = 1'b1;
    for (int n = 0; n <= 9; n++) begin
      tick();
      if (n == 0) lv_b = 1'b0;
      if (n < 8) begin
        e_rs = 8'(1 << n);
        e_cd = seq_bytes[n];
      end else begin
        e_rs = 8'h00;
        e_cd = 8'h00;
      end
      check($sformatf("b_rs_n%0d", n),   64'(rs_b),   64'(e_rs));
      check($sformatf("b_cd_n%0d", n),   64'(cd_b),   64'(e_cd));
      check($sformatf("b_fd_n%0d", n),   64'(fd_b),   64'(n == 8));
      check($sformatf("b_gr_n%0d", n),   64'(gr_b),   64'(n == 8));
      check($sformatf("b_busy_n%0d", n), 64'(busy_b), 64'(n < 8));
      check($sformatf("b_lr_n%0d", n),   64'(lr_b),   64'(n >= 8));
    end

    // Diagonal snapshot; disturb grid/load_valid mid-scan, then hold load_valid for back-to-back.
    grid_a = DIAG;
    lv_a   = 1'b1;
    step_a(DIAG, 0);
    lv_a   = 1'b0;
    for (int n = 1; n <= 48; n++) begin
      step_a(DIAG, n);
      if (n == 10) begin
        grid_a = {64{1'b1}};
        lv_a   = 1'b1;
      end
      if (n == 11) lv_a = 1'b0;
      if (n == 30) begin
        grid_a = STRIP;
        lv_a   = 1'b1;
      end
    end

    // Accepted on the gen_req cycle, so row 0 of the new snapshot follows directly.
    step_a(STRIP, 0);
    lv_a = 1'b0;
    for (int n = 1; n <= 33; n++) step_a(STRIP, n);

    // Now in frame 1, row 3: pull reset between clock edges.
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_a("async_rst");
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check_idle_a("post_rst0");
    tick();
    check_idle_a("post_rst1");

    grid_a = ANTI;
    lv_a   = 1'b1;
    step_a(ANTI, 0);
    lv_a   = 1'b0;
    for (int n = 1; n <= 48; n++) step_a(ANTI, n);
    tick();
    check("a_after_gr_gr", 64'(gr_a), 64'h0);
    check("a_after_gr_fd", 64'(fd_a), 64'h0);
    check("a_after_gr_lr", 64'(lr_a), 64'h1);
    check("a_after_gr_rs", 64'(rs_a), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/grid_scanner.md
Name: grid_scanner

Overview:
- Read-side counterpart to the Game of Life datapath: takes one 64-bit generation snapshot through a valid/ready handshake and drives an 8x8 row-multiplexed LED matrix.
- Scans the snapshot row by row for a fixed number of full frames.
- After the last frame it pulses gen_req to ask the controller for the next evolution, then accepts the next snapshot.
- Sits between the generation register and the board-level matrix pins.

Parameters:
DWELL, 4, cycles each row is lit (>=1)
BLANK, 1, blanking cycles after each row, all rows off (>=0; 0 = no blanking)
FRAMES, 2, full 8-row scans per accepted snapshot (>=1)

Ports:
clk  in  1  system clock, rising-edge
reset_n  in  1  reset, asynchronous, active-low
grid  in  64  generation snapshot; grid[8*r+c] = row r, column c
load_valid  in  1  snapshot on grid is valid
load_ready  out  1  block can accept a snapshot
row_sel  out  8  one-hot active-high row enable; bit r = row r
col_data  out  8  column drive for the selected row; bit c = column c
frame_done  out  1  one-cycle pulse at the end of each full 8-row scan
gen_req  out  1  one-cycle pulse after the final frame; request next generation
busy  out  1  high while scanning

Behaviour:
- Reset (reset_n low, asynchronous, takes effect immediately, including mid-scan):
  - State: IDLE.
  - Frame buffer, row counter, dwell/blank counter and frame counter all 0.
  - Outputs: row_sel=0, col_data=0, frame_done=0, gen_req=0, busy=0, load_ready=1.
- All outputs are registered.
- States: IDLE, SCAN, BLANK.
- IDLE:
  - load_ready=1, busy=0, row_sel=0, col_data=0.
  - Handshake occurs at a rising edge with load_valid=1 and load_ready=1.
  - At that edge: buffer<=grid, row<=0, frame<=0, counter<=0, go to SCAN.
  - The outputs after that edge are row_sel=8'h01, col_data=grid[7:0], busy=1, load_ready=0 (zero-latency first row).
- SCAN:
  - row_sel = 1<<row, col_data = buffer[8*row +: 8].
  - The row is held for exactly DWELL cycles.
  - Then go to BLANK if BLANK>0. Otherwise go directly to the next row.
- BLANK:
  - row_sel=0, col_data=0 for exactly BLANK cycles.
  - Then advance to the next row.
- Row advance:
  - If row<7: row+1, go to SCAN.
  - If row==7: the frame ends.
- Frame end:
  - frame_done is high for one cycle, aligned with the first cycle of the next row 0 or with the first IDLE cycle.
  - If frame<FRAMES-1: frame+1, row<=0, go to SCAN (row wraps 7->0).
  - Otherwise go to IDLE. gen_req is high for that same single cycle, together with frame_done, and load_ready=1 in that cycle.
- Frame period is 8*(DWELL+BLANK) cycles. From handshake to gen_req is FRAMES*8*(DWELL+BLANK) cycles.
- While busy:
  - load_valid is ignored.
  - Changes on grid do not affect the buffer or the outputs.
- Back-to-back: load_valid held high is accepted in the first IDLE cycle, i.e. the same cycle gen_req is asserted. No dead cycle.
- Counters are sized to $clog2 of the parameter plus 1. No overflow at the parameter maxima.
- row_sel is never multi-hot. In IDLE and BLANK it is exactly 0.

Test Plan:
- Reset then release, DWELL=2/BLANK=1/FRAMES=2, load_valid=0 for 10 cycles -> load_ready=1, row_sel=0, col_data=0, busy=0, no pulses.
- Load grid=64'h8040201008040201 -> row r shows col_data = 1<<r for 2 cycles, then 1 blank cycle. frame_done at cycle 24 and cycle 48 after the handshake; gen_req only at cycle 48, coincident with load_ready=1.
- During the scan, change grid to all-ones and pulse load_valid -> col_data still follows the diagonal pattern. load_ready stays 0.
- load_valid held high continuously with grid=64'hFFFF_0000_FFFF_0000 -> second snapshot accepted on the gen_req cycle. Row 0 of the new frame appears the next cycle with col_data=8'h00; row 2 shows 8'hFF.
- BLANK=0, DWELL=1, FRAMES=1, grid=64'h0123456789ABCDEF -> 8 consecutive cycles with row_sel walking 01..80 and col_data EF,CD,AB,89,67,45,23,01. frame_done and gen_req high together in cycle 8.
- Assert reset_n low mid-row-3 (asynchronously, between clock edges) -> outputs return to reset values immediately. After release, the block is in IDLE and a new load restarts at row 0, frame 0.
